// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and decode helpers for the load/store unit.
//   lsu_state_e  FSM state encoding (IDLE, RD, WR, RESP)
//   F3_*         RV32I funct3 size/sign codes
//   is_legal     funct3 valid for the given direction
//   is_aligned   natural alignment of the byte address for funct3's size
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads.
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  // f3[1:0] carries the size for every legal code; illegal codes are
  // rejected by is_legal regardless of what this returns.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a1_0);
    case (f3[1:0])
      2'b01:   return !a1_0[0];
      2'b10:   return a1_0 == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane muxes for the load/store unit.
//   funct3, lane  access size/sign and byte offset within the word
//   rword         captured memory word -> load_data (extracted + extended)
//   mword         word being read back for RMW -> store_word (merged)
//   wdata         right-aligned store data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] rword,
  input  logic [DATA_WIDTH-1:0] mword,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_word
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Little-endian extract; halfwords are aligned so lane[0] is ignored.
  always_comb begin
    byte_v    = rword[{lane, 3'b000} +: 8];
    half_v    = rword[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_H:    load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      F3_W:    load_data = rword;
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: load_data = '0;
    endcase
  end

  // Merge: replicate the store data across lanes, then pick per byte.
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] rep, base, merged;

  always_comb begin
    be  = '1;
    rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be  = NUM_LANES'(1) << lane;
        rep = {NUM_LANES{wdata[7:0]}};
      end
      2'b01: begin
        be  = NUM_LANES'(3) << {lane[1], 1'b0};
        rep = {(NUM_LANES/2){wdata[15:0]}};
      end
      default: begin
        be  = '1;
        rep = wdata;
      end
    endcase
  end

  assign base = mword;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = be[i] ? rep[i] : base[i];
  end

  assign store_word = merged;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit in front of a word-only,
// fixed-latency data memory. One request in flight; SB/SH are done as
// read-modify-write; misaligned/illegal requests answer with resp_err and
// never touch memory.
//   req_*   request handshake (valid/ready) with we, funct3, addr, wdata
//   resp_*  one-cycle completion pulse with extended load data / error
//   mem_*   word-aligned memory port; read data valid MEM_LAT edges after
//           the address is first presented
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 2);

  lsu_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic                  we_q, err_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, mem_addr_q, mem_wdata_q;
  logic [DATA_WIDTH-1:0] load_data, store_word;
  logic                  req_ok, cnt_done;

  assign req_ok   = is_legal(req_we, req_funct3) && is_aligned(req_funct3, req_addr[1:0]);
  assign cnt_done = (cnt_q == '0);

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (f3_q),
    .lane       (lane_q),
    .rword      (rdata_q),
    .mword      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = (state_q == S_IDLE);
    mem_read   = (state_q == S_RD);
    mem_write  = (state_q == S_WR);
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) && err_q;
    resp_rdata = '0;
    if (state_q == S_RESP && !err_q && !we_q) resp_rdata = load_data;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (!req_ok)                          state_d = S_RESP;
        else if (req_we && req_funct3 == F3_W) state_d = S_WR;
        else                                  state_d = S_RD;
      end
      S_RD:   if (cnt_done) state_d = we_q ? S_WR : S_RESP;
      S_WR:   if (cnt_done) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          err_q   <= !req_ok;
          f3_q    <= req_funct3;
          lane_q  <= req_addr[1:0];
          wdata_q <= req_wdata;
          cnt_q   <= CW'(MEM_LAT);
          // Rejected requests leave the memory port untouched.
          if (req_ok) mem_addr_q <= {req_addr[DATA_WIDTH-1:2], 2'b00};
          if (req_ok && req_we && req_funct3 == F3_W) mem_wdata_q <= req_wdata;
        end
        S_RD: begin
          if (cnt_done) begin
            rdata_q <= mem_rdata;
            cnt_q   <= CW'(MEM_LAT);
            if (we_q) mem_wdata_q <= store_word;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WR: if (!cnt_done) cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory plus a per-request
// schedule model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic.
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i + 1) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- simulated dmem (0x100..0x1FF) ----------------
  logic [31:0] smem [0:63];
  bit          smem_ld = 0;
  int          age = 0;
  logic [31:0] age_addr = '0;
  logic        in_rng;
  logic [5:0]  sidx;
  assign in_rng = (mem_addr >= 32'h100) && (mem_addr < 32'h200);
  assign sidx   = 6'((mem_addr - 32'h100) >> 2);
  // Garbage until the address has been held for LAT edges.
  assign mem_rdata = (mem_read && age >= LAT && in_rng) ? smem[sidx] : 32'hA5A5_5A5A;

  always @(posedge clk) begin
    if (!smem_ld) begin
      for (int i = 0; i < 64; i++) smem[i] <= seed_word(i);
      smem_ld <= 1;
    end else if (mem_write && in_rng) smem[sidx] <= mem_wdata;
    if (mem_read) begin
      age      <= (age != 0 && mem_addr != age_addr) ? 1 : age + 1;
      age_addr <= mem_addr;
    end else age <= 0;
  end

  // ---------------- reference model ----------------
  logic [7:0]  rmem [0:255];
  bit          rmem_ld = 0, inited = 0, busy = 0, t_err = 0, legal, e_ready, e_rv;
  int          k = 0, rd_lo, rd_hi, wr_lo, wr_hi, t_resp, sz, o;
  int          n_acc = 0, n_abort = 0, n_resp_dut = 0, last_acc = 0, prev_acc = 0;
  logic [31:0] t_rdata, t_addr, t_wdata, m_addr = '0, m_wdata = '0;
  logic [31:0] obs_rdata = '0, obs_wdata = '0;
  logic [15:0] hv;
  logic [7:0]  bv;
  bit          obs_err = 0;
  int          obs_lat = 0;

  function automatic logic [31:0] rword(input logic [31:0] a);
    int b;
    b = int'((a & ~32'h3) - 32'h100);
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction

  always @(posedge clk) k++;

  always @(negedge clk) begin
    e_ready = !busy;
    if (inited) begin
      if (busy && (k == rd_lo || k == wr_lo)) m_addr = t_addr;
      if (busy && k == wr_lo) m_wdata = t_wdata;
      e_rv = busy && k == t_resp;
      chk("req_ready",  32'(req_ready),  32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("resp_err",   32'(resp_err),   32'(e_rv && t_err));
      chk("resp_rdata", resp_rdata,      e_rv ? t_rdata : 32'h0);
      chk("mem_read",   32'(mem_read),   32'(busy && k >= rd_lo && k <= rd_hi));
      chk("mem_write",  32'(mem_write),  32'(busy && k >= wr_lo && k <= wr_hi));
      chk("mem_addr",   mem_addr,        m_addr);
      chk("mem_wdata",  mem_wdata,       m_wdata);
      if (resp_valid) begin
        n_resp_dut++;
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        obs_lat   = k - last_acc;
      end
      if (mem_write) obs_wdata = mem_wdata;
      if (e_rv) busy = 0;
    end
    if (!rst_n) begin
      if (!rmem_ld) begin
        for (int i = 0; i < 64; i++) begin
          t_wdata = seed_word(i);
          for (int j = 0; j < 4; j++) rmem[4*i+j] = t_wdata[8*j +: 8];
        end
        rmem_ld = 1;
      end
      if (busy) n_abort++;
      busy = 0; m_addr = '0; m_wdata = '0; inited = 1;
    end else if (inited && e_ready && req_valid) begin
      sz    = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
      legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                     : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      legal = legal && (req_addr % sz == 0);
      o = int'(req_addr - 32'h100);
      t_err = !legal; t_addr = req_addr & ~32'h3; t_rdata = '0;
      rd_lo = -1; rd_hi = -1; wr_lo = -1; wr_hi = -1;
      if (!legal) t_resp = k + 1;
      else if (req_we) begin
        for (int j = 0; j < sz; j++) rmem[o+j] = req_wdata[8*j +: 8];
        t_wdata = rword(req_addr);
        if (sz == 4) begin
          wr_lo = k + 1; wr_hi = k + 1 + LAT; t_resp = k + LAT + 2;
        end else begin
          rd_lo = k + 1; rd_hi = k + 1 + LAT;
          wr_lo = k + LAT + 2; wr_hi = k + 2*LAT + 2; t_resp = k + 2*LAT + 3;
        end
      end else begin
        rd_lo = k + 1; rd_hi = k + 1 + LAT; t_resp = k + LAT + 2;
        if (sz == 1) begin
          bv = rmem[o];
          t_rdata = req_funct3[2] ? {24'h0, bv} : {{24{bv[7]}}, bv};
        end else if (sz == 2) begin
          hv = {rmem[o+1], rmem[o]};
          t_rdata = req_funct3[2] ? {16'h0, hv} : {{16{hv[15]}}, hv};
        end else t_rdata = rword(req_addr);
      end
      busy = 1; n_acc++; prev_acc = last_acc; last_acc = k;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int n0;
    bit got;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    n0 = n_acc; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      if (n_acc != n0) got = 1;
    end
    #1;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: request at %h never accepted", a);
    end
    if (!hold) begin
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 40) begin @(negedge clk); i++; end
    @(posedge clk); #1;
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: got busy, expected idle");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit h;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_addr", mem_addr, 32'h0);

    issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 0); wait_idle();
    chk("sw_lat", 32'(obs_lat), 32'd5);
    issue(0, 3'b010, 32'h100, 32'h0, 0); wait_idle();
    chk("lw_data", obs_rdata, 32'hDEADBEEF);
    chk("lw_lat", 32'(obs_lat), 32'd5);
    issue(1, 3'b000, 32'h101, 32'h000000AA, 0); wait_idle();
    chk("sb_word", obs_wdata, 32'hDEADAAEF);
    chk("sb_lat", 32'(obs_lat), 32'd9);
    issue(0, 3'b000, 32'h101, 32'h0, 0); wait_idle();
    chk("lb_data", obs_rdata, 32'hFFFFFFAA);
    issue(0, 3'b100, 32'h101, 32'h0, 0); wait_idle();
    chk("lbu_data", obs_rdata, 32'h000000AA);
    issue(1, 3'b001, 32'h102, 32'h00001234, 0); wait_idle();
    chk("sh_word", obs_wdata, 32'h1234AAEF);
    issue(0, 3'b001, 32'h102, 32'h0, 0); wait_idle();
    chk("lh_data", obs_rdata, 32'h00001234);
    issue(0, 3'b101, 32'h100, 32'h0, 0); wait_idle();
    chk("lhu_data", obs_rdata, 32'h0000AAEF);

    issue(0, 3'b010, 32'h102, 32'h0, 0); wait_idle();
    chk("lw_mis_err", 32'(obs_err), 32'h1);
    chk("lw_mis_lat", 32'(obs_lat), 32'd1);
    issue(0, 3'b001, 32'h103, 32'h0, 0); wait_idle();
    chk("lh_mis_err", 32'(obs_err), 32'h1);
    issue(0, 3'b011, 32'h100, 32'h0, 0); wait_idle();
    chk("f3_ill_err", 32'(obs_err), 32'h1);
    chk("f3_ill_data", obs_rdata, 32'h0);

    issue(0, 3'b010, 32'h100, 32'h0, 1);
    issue(0, 3'b010, 32'h104, 32'h0, 0); wait_idle();
    chk("b2b_gap", 32'(last_acc - prev_acc), 32'd6);

    issue(0, 3'b010, 32'h100, 32'h0, 0);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("abort_cnt", 32'(n_abort), 32'd1);
    chk("resp_cnt", 32'(n_resp_dut), 32'(n_acc - n_abort));
    issue(0, 3'b010, 32'h100, 32'h0, 0); wait_idle();
    chk("lw_after_rst", obs_rdata, 32'h1234AAEF);

    for (int n = 0; n < 300; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      h = ($urandom_range(0, 3) == 0);
      issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, h);
      if (!h) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req_valid = 0;
    wait_idle();
    chk("resp_cnt_end", 32'(n_resp_dut), 32'(n_acc - n_abort));
    for (int i = 0; i < 64; i++)
      chk("mem_final", smem[i], {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
